// File: rtl/lz77_dec.sv
// LZ77 codeword decoder: expands (pos, len, chr) codewords into a byte stream,
// copying from a search-buffer shift register, then emitting the literal.
module lz77_dec #(
  parameter int          SBUF_DEPTH = 9,
  parameter int          POS_W      = 4,
  parameter int          LEN_W      = 4,
  parameter logic [7:0]  END_CHR    = 8'h24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  output logic             code_ready,
  input  logic [POS_W-1:0] code_pos,
  input  logic [LEN_W-1:0] code_len,
  input  logic [7:0]       code_chr,
  output logic             out_valid,
  output logic [7:0]       out_chr,
  output logic             finish
);
  typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_t;

  state_t                           state, state_nxt;
  logic [SBUF_DEPTH-1:0][7:0]       sbuf;
  logic [POS_W-1:0]                 pos_q;
  logic [LEN_W-1:0]                 len_q, cnt;
  logic [7:0]                       chr_q, rd_chr;
  logic                             acc;

  assign code_ready = (state == IDLE);
  assign acc        = code_valid && code_ready;

  // Positions beyond the buffer fall through to the 8'h00 default.
  always_comb begin
    rd_chr = '0;
    for (int i = 0; i < SBUF_DEPTH; i++)
      if (pos_q == POS_W'(i)) rd_chr = sbuf[i];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc) state_nxt = (code_len != '0) ? COPY : LIT;
      COPY: if (cnt == len_q - LEN_W'(1)) state_nxt = LIT;
      LIT:  state_nxt = (chr_q == END_CHR) ? DONE : IDLE;
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sbuf      <= '0;
      pos_q     <= '0;
      len_q     <= '0;
      chr_q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_chr   <= 8'h00;
      finish    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          pos_q <= code_pos;
          len_q <= code_len;
          chr_q <= code_chr;
          cnt   <= '0;
        end
        // pos_q stays fixed while the buffer shifts, so overlapping copies repeat the pattern.
        COPY: begin
          out_chr   <= rd_chr;
          out_valid <= 1'b1;
          sbuf      <= {sbuf[SBUF_DEPTH-2:0], rd_chr};
          cnt       <= cnt + LEN_W'(1);
        end
        LIT: begin
          out_chr   <= chr_q;
          out_valid <= 1'b1;
          sbuf      <= {sbuf[SBUF_DEPTH-2:0], chr_q};
          if (chr_q == END_CHR) finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lz77_dec.sv
// Directed bench for lz77_dec: a reference buffer model pushes expected
// (cycle, char) pairs; a negedge monitor pops and compares DUT output.
module tb_lz77_dec;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic [3:0] code_pos = '0;
  logic [3:0] code_len = '0;
  logic [7:0] code_chr = '0;
  logic       out_valid;
  logic [7:0] out_chr;
  logic       finish;

  typedef struct { int cyc; logic [7:0] chr; } exp_t;
  exp_t       q[$];
  logic [7:0] m [0:8];
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;

  lz77_dec dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_ready(code_ready),
    .code_pos(code_pos), .code_len(code_len), .code_chr(code_chr),
    .out_valid(out_valid), .out_chr(out_chr), .finish(finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_shift(input logic [7:0] c);
    for (int i = 8; i > 0; i--) m[i] = m[i-1];
    m[0] = c;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m[i] = 8'h00;
  endtask

  // Scoreboard side: every emitted char must match the head of the queue, in the predicted cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_chr", out_chr, e.chr);
        chk("out_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [3:0] p, input logic [3:0] l, input logic [7:0] c, output int k);
    int n;
    logic [7:0] ch;
    n = 0;
    @(negedge clk);
    while (code_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", code_ready, 1'b1);
    code_valid = 1'b1; code_pos = p; code_len = l; code_chr = c;
    @(posedge clk); #1;
    k = cyc;
    code_valid = 1'b0;
    code_pos = 4'($urandom); code_len = 4'($urandom); code_chr = 8'($urandom);
    for (int j = 0; j < int'(l); j++) begin
      ch = (int'(p) < 9) ? m[int'(p)] : 8'h00;
      model_shift(ch);
      q.push_back('{k + 1 + j, ch});
    end
    model_shift(c);
    q.push_back('{k + 1 + int'(l), c});
  endtask

  task automatic ready_gap(input int k, input int l);
    int n;
    n = 0;
    @(negedge clk);
    while (code_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("ready_return_cyc", cyc, k + l + 1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk(tag, q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_clear();
    q.delete();
  endtask

  initial begin
    int k;
    model_clear();
    // Reset held two cycles with code_valid asserted.
    code_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", code_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_chr", out_chr, 8'h00);
      chk("rst_finish", finish, 1'b0);
    end
    reset = 1'b0; code_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", code_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);

    // Literal only.
    send(4'd0, 4'd0, 8'h41, k);
    ready_gap(k, 0);
    drain("lit_drain");

    // Overlapping copy after emitting 41, 42.
    do_reset();
    send(4'd0, 4'd0, 8'h41, k);
    send(4'd0, 4'd0, 8'h42, k);
    send(4'd1, 4'd5, 8'h43, k);
    ready_gap(k, 5);
    drain("overlap_drain");

    // Back-to-back short copies with in-range positions.
    send(4'd2, 4'd3, 8'h44, k);
    send(4'd8, 4'd1, 8'h45, k);
    drain("b2b_drain");

    // Out-of-range position on a cleared buffer.
    do_reset();
    send(4'd12, 4'd2, 8'h5A, k);
    drain("oor_drain");

    // Length above the encoder range still copies exactly that many.
    send(4'd0, 4'd11, 8'h46, k);
    drain("len11_drain");

    // End marker.
    do_reset();
    send(4'd0, 4'd0, 8'h41, k);
    send(4'd0, 4'd1, 8'h24, k);
    @(negedge clk);
    while (cyc < k + 2) @(negedge clk);
    chk("end_out_chr", out_chr, 8'h24);
    chk("end_out_valid", out_valid, 1'b1);
    chk("end_finish", finish, 1'b1);
    drain("end_drain");
    repeat (4) begin
      code_valid = 1'b1; code_pos = 4'd0; code_len = 4'd0; code_chr = 8'h55;
      @(negedge clk);
      chk("done_ready", code_ready, 1'b0);
      chk("done_out_valid", out_valid, 1'b0);
      chk("done_finish", finish, 1'b1);
    end
    code_valid = 1'b0;

    // Reset during the third COPY cycle of a len-8 copy.
    do_reset();
    send(4'd0, 4'd8, 8'h30, k);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_ready", code_ready, 1'b1);
    chk("midrst_finish", finish, 1'b0);
    #1;
    q.delete();
    model_clear();
    send(4'd0, 4'd1, 8'h31, k);
    drain("midrst_drain");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/lz77_dec.md
# lz77_dec

Sliding-window LZ77 decoder: the consumer end of the codeword stream produced by the LZ77 encoder's match search. It accepts (offset, length, next-char) codewords over a valid/ready handshake and reconstructs the byte stream one character per cycle. It does this by copying from a 9-entry search-buffer shift register and then emitting the literal. A codeword whose literal equals the end marker terminates decoding and raises `finish`.

## Interface
- `SBUF_DEPTH`, 9: search-buffer entries. Entry 0 holds the most recently emitted char.
- `POS_W`, 4: width of `code_pos`.
- `LEN_W`, 4: width of `code_len`. The encoder produces 0..8.
- `END_CHR`, 8'h24: end-of-stream literal (`$`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `code_valid` in 1: codeword present.
- `code_ready` out 1: decoder can accept a codeword.
- `code_pos` in POS_W: search-buffer index to copy from.
- `code_len` in LEN_W: number of chars to copy before the literal.
- `code_chr` in 8: literal emitted after the copy.
- `out_valid` out 1: `out_chr` valid this cycle. There is no output backpressure.
- `out_chr` out 8: decoded character.
- `finish` out 1: end marker has been emitted. Sticky until reset.

## Operation
- Reset (synchronous, active-high) values: state IDLE, `code_ready`=1, `out_valid`=0, `out_chr`=8'h00, `finish`=0, all search-buffer entries 8'h00, copy counter 0.
- Reset asserted mid-operation aborts the codeword in progress. The partial output is not completed.
- States: IDLE, COPY, LIT, DONE.
- IDLE
  - `code_ready`=1.
  - On `code_valid && code_ready`, latch pos, len and chr, and clear the counter.
  - Go to COPY if len!=0, else go to LIT.
- COPY
  - `code_ready`=0.
  - Each cycle: `out_chr` <= buf[pos], `out_valid` <= 1, the search buffer shifts (buf[i+1] <= buf[i], buf[0] <= the copied char), and the counter increments.
  - The latched pos stays fixed while the buffer shifts, so a self-overlapping copy (len > pos+1) replicates the pattern naturally.
  - When counter == len-1, go to LIT.
- LIT
  - `out_chr` <= latched chr, `out_valid` <= 1, and chr shifts into buf[0].
  - If chr == END_CHR: `finish` <= 1 and go to DONE. Otherwise go to IDLE.
- DONE: `code_ready`=0 and `out_valid` <= 0. `code_valid` is ignored. Only reset exits.
- In any state other than COPY or LIT, `out_valid` <= 0 and `out_chr` holds its last value.
- `code_pos` >= SBUF_DEPTH reads 8'h00. This must not assert; it is a defined value.
- `code_len` is used as given (0..15). Values above 8 are outside the encoder's range, but the decoder still copies exactly that many chars.
- `code_pos`/`code_len`/`code_chr` are sampled only on the accepting edge. Changes afterwards have no effect.

## Timing
- Handshake in cycle t. COPY occupies cycles t+1..t+len, and LIT occupies cycle t+len+1.
- `out_chr` and `out_valid` are registered. The decoded chars therefore appear in cycles t+2..t+len+2, one per cycle with no bubbles.
- `code_ready` returns high in cycle t+len+2, which is the same cycle the literal appears on `out_chr`.
- The earliest next handshake is cycle t+len+2. Its first char appears in t+len+4, so there is exactly one idle output cycle between codewords when the stream is back-to-back.
- `finish` rises in the same cycle that END_CHR appears on `out_chr` (with `out_valid`=1) and remains high. `out_valid` is 0 from the next cycle onward.
- Throughput is len+2 cycles per codeword.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `code_valid`=1 -> `code_ready`=1, `out_valid`=0, `out_chr`=00, `finish`=0 during and after reset. No char is emitted.
- **Literal only:** codeword (pos 0, len 0, chr 8'h41) accepted in cycle t -> `out_valid`=1 with `out_chr`=41 only in cycle t+2. `code_ready` is high again in t+2.
- **Overlapping copy:** emit 41, then 42 via two literal-only codewords, then send (pos 1, len 5, chr 43) -> `out_chr` sequence 41,42,41,42,41,43 over 6 consecutive cycles. `code_ready` is low for exactly 6 cycles after the accept.
- **Out-of-range pos on a fresh buffer:** (pos 12, len 2, chr 5A) -> 00,00,5A.
- **End marker:** (pos 0, len 1, chr 24) after a 41 has been emitted -> outputs 41,24. `finish`=1 in the 24 cycle and stays high. `code_ready` stays 0, and subsequent `code_valid` pulses produce no output.
- **Reset mid-copy:** start (pos 0, len 8, chr 30) and assert `reset` during the third COPY cycle -> `out_valid`=0 and `code_ready`=1 the next cycle. Then (pos 0, len 1, chr 31) -> outputs 00,31, confirming the buffer was cleared.
